// File: rtl/uart_evt_link.sv
// UART link for the voice/alarm board: 8N1 receiver with play-address decode, plus an
// edge-triggered multi-channel event queue that serialises one code byte per event.
module uart_evt_link #(
    parameter int unsigned BAUD_DIV   = 5208,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned N_EVT      = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    uart_data_rx,
    input  logic [N_EVT-1:0]        evt_req,
    input  logic [N_EVT*DATA_W-1:0] evt_code,
    output logic                    serial_data_tx,
    output logic [DATA_W-1:0]       rx_data,
    output logic                    rx_valid,
    output logic                    rx_frame_err,
    output logic [DATA_W-2:0]       play_addr,
    output logic                    play_strobe,
    output logic                    tx_busy,
    output logic                    fifo_full,
    output logic [N_EVT-1:0]        evt_overrun
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned BW = $clog2(DATA_W);
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

    // ---------------- receive path ----------------
    logic rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_e rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [BW-1:0] rx_bit_q, rx_bit_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic rx_valid_q, rx_valid_d, rx_err_q, rx_err_d;
    logic [DATA_W-2:0] play_addr_q, play_addr_d;
    logic play_strobe_q, play_strobe_d;

    // Synchroniser flops reset high so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= uart_data_rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    always_comb begin
        rx_state_d    = rx_state_q;
        rx_cnt_d      = rx_cnt_q;
        rx_bit_d      = rx_bit_q;
        rx_shift_d    = rx_shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        rx_err_d      = 1'b0;
        play_addr_d   = play_addr_q;
        play_strobe_d = 1'b0;
        case (rx_state_q)
            RxIdle: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = RxStart;
                    rx_cnt_d   = '0;
                end
            end
            RxStart: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? RxIdle : RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RxData: begin
                if (rx_cnt_q == BAUD_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[DATA_W-1:1]};
                    if (rx_bit_q == BIT_LAST) begin
                        rx_state_d = RxStop;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RxStop: begin
                if (rx_cnt_q == BAUD_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RxIdle;
                    if (rx_s2_q) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                        // MSB set marks a play command; the low bits are the address.
                        if (rx_shift_q[DATA_W-1]) begin
                            play_addr_d   = rx_shift_q[DATA_W-2:0];
                            play_strobe_d = 1'b1;
                        end
                    end else begin
                        rx_err_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q    <= RxIdle;
            rx_cnt_q      <= '0;
            rx_bit_q      <= '0;
            rx_shift_q    <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_err_q      <= 1'b0;
            play_addr_q   <= '0;
            play_strobe_q <= 1'b0;
        end else begin
            rx_state_q    <= rx_state_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_bit_q      <= rx_bit_d;
            rx_shift_q    <= rx_shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_err_q      <= rx_err_d;
            play_addr_q   <= play_addr_d;
            play_strobe_q <= play_strobe_d;
        end
    end

    // ---------------- event capture and arbiter ----------------
    logic [N_EVT-1:0] req_q, req_qq, rise;
    logic [N_EVT-1:0] pend_q, pend_d, ovr_q, ovr_d, grant;
    logic [DATA_W-1:0] push_data;
    logic push, pop, fifo_empty, found;

    assign rise = req_q & ~req_qq;

    always_comb begin
        grant     = '0;
        push_data = '0;
        found     = 1'b0;
        for (int i = 0; i < N_EVT; i++) begin
            if (pend_q[i] && !found && !fifo_full) begin
                grant[i]  = 1'b1;
                push_data = evt_code[i*DATA_W +: DATA_W];
                found     = 1'b1;
            end
        end
        push   = found;
        pend_d = (pend_q & ~grant) | rise;
        ovr_d  = ovr_q | (rise & pend_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q  <= '0;
            req_qq <= '0;
            pend_q <= '0;
            ovr_q  <= '0;
        end else begin
            req_q  <= evt_req;
            req_qq <= req_q;
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
        end
    end

    // ---------------- TX queue ----------------
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0] wptr_q, rptr_q;

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + (AW+1)'(1);
            if (pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    // ---------------- transmit path ----------------
    tx_state_e tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [BW-1:0] tx_bit_q, tx_bit_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic tx_line_q, tx_line_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        pop        = 1'b0;
        case (tx_state_q)
            TxIdle: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    tx_shift_d = mem[rptr_q[AW-1:0]];
                    tx_cnt_d   = '0;
                    tx_state_d = TxStart;
                end
            end
            TxStart: begin
                if (tx_cnt_q == BAUD_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TxData;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            TxData: begin
                if (tx_cnt_q == BAUD_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == BIT_LAST) begin
                        tx_state_d = TxStop;
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            TxStop: begin
                if (tx_cnt_q == BAUD_LAST) begin
                    tx_cnt_d = '0;
                    // Chain straight into the next frame so back-to-back bytes have no gap.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        tx_shift_d = mem[rptr_q[AW-1:0]];
                        tx_state_d = TxStart;
                    end else begin
                        tx_state_d = TxIdle;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            default: tx_state_d = TxIdle;
        endcase
        case (tx_state_d)
            TxStart: tx_line_d = 1'b0;
            TxData:  tx_line_d = tx_shift_d[0];
            default: tx_line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
        end
    end

    assign serial_data_tx = tx_line_q;
    assign rx_data        = rx_data_q;
    assign rx_valid       = rx_valid_q;
    assign rx_frame_err   = rx_err_q;
    assign play_addr      = play_addr_q;
    assign play_strobe    = play_strobe_q;
    assign evt_overrun    = ovr_q;
    assign tx_busy        = (tx_state_q != TxIdle) | ~fifo_empty | (|pend_q);

endmodule
